// File: rtl/seq_mult_nxn_if.sv
// Start/done handshake bundle for the sequential NxN multiplier.
// The master drives the request (start, mode, operands); the slave returns
// busy/done status and the product.
interface seq_mult_nxn_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/seq_mult_nxn.sv
// Sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH bits.
// One multiplier bit is consumed per clock. Signed operands are converted to
// magnitudes at capture, and the sign is reapplied once when loading the
// product, so the datapath itself is purely unsigned.
module seq_mult_nxn #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_mult_nxn_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [PW-1:0]    mcand;      // multiplicand, shifted left each step
    logic [WIDTH-1:0] mplier;     // multiplier, shifted right each step
    logic [PW-1:0]    acc;
    logic [CW-1:0]    cnt;
    logic             neg;        // result must be negated at completion
    logic [PW-1:0]    acc_sum;
    logic             busy_q;
    logic             done_q;
    logic [PW-1:0]    product_q;

    // Magnitude of an operand; the most negative value maps to 2^(WIDTH-1),
    // which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sm);
        return (sm && x[WIDTH-1]) ? -x : x;
    endfunction

    // Partial-product add for the current multiplier LSB.
    always_comb begin
        acc_sum = acc + (mplier[0] ? mcand : '0);
    end

    // Control FSM and datapath; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        mcand  <= {{WIDTH{1'b0}}, mag(bus.a, bus.signed_mode)};
                        mplier <= mag(bus.b, bus.signed_mode);
                        neg    <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        // Last bit: load the product directly from this step's sum.
                        product_q <= neg ? -acc_sum : acc_sum;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule

// File: tb/tb_seq_mult_nxn.sv
// Self-checking bench: a WIDTH=3 instance for the exhaustive unsigned sweep
// and a WIDTH=8 instance for signed corners, random operands, handshake,
// hold and reset behaviour. Expected products come from plain integer math.
module tb_seq_mult_nxn;
    logic clk = 1'b0;
    logic rst3_n, rst8_n;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    seq_mult_nxn_if #(.WIDTH(3)) if3 ();
    seq_mult_nxn_if #(.WIDTH(8)) if8 ();

    seq_mult_nxn #(.WIDTH(3)) u3 (.clk(clk), .rst_n(rst3_n), .bus(if3.slave));
    seq_mult_nxn #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst8_n), .bus(if8.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference product: interpret operands per mode, multiply, keep 2*w bits.
    function automatic longint ref_mul(input longint a, input longint b, input bit sm, input int w);
        longint sa = a;
        longint sb = b;
        longint one = 1;
        if (sm && a[w-1]) sa = a - (one << w);
        if (sm && b[w-1]) sb = b - (one << w);
        return (sa * sb) & ((one << (2 * w)) - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 transaction from IDLE: returns product, latency, busy cycles.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit sm,
                        output logic [15:0] p, output int lat, output int bcnt);
        if8.a = a; if8.b = b; if8.signed_mode = sm; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        lat = 0; bcnt = 0;
        while (!if8.done && lat < 40) begin
            if (if8.busy) bcnt++;
            tick();
            lat++;
        end
        p = if8.product;
        tick();   // DONE -> IDLE
    endtask

    task automatic run3(input logic [2:0] a, input logic [2:0] b,
                        output logic [5:0] p, output int lat);
        if3.a = a; if3.b = b; if3.signed_mode = 1'b0; if3.start = 1'b1;
        tick();
        if3.start = 1'b0;
        lat = 0;
        while (!if3.done && lat < 20) begin
            tick();
            lat++;
        end
        p = if3.product;
        tick();
    endtask

    initial begin
        logic [15:0] p8;
        logic [5:0]  p3;
        int lat, bcnt, dcnt, bad, t0;

        rst3_n = 1'b0; rst8_n = 1'b0;
        if3.start = 1'b0; if3.a = '0; if3.b = '0; if3.signed_mode = 1'b0;
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.signed_mode = 1'b0;
        #12;
        chk("rst_busy", if8.busy, 0);
        chk("rst_done", if8.done, 0);
        chk("rst_prod", if8.product, 0);
        chk("rst3_prod", if3.product, 0);
        tick();
        rst3_n = 1'b1; rst8_n = 1'b1;

        // Exhaustive unsigned WIDTH=3: mismatches reported individually.
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                run3(3'(i), 3'(j), p3, lat);
                chk($sformatf("w3_%0dx%0d", i, j), p3, ref_mul(i, j, 0, 3));
                chk($sformatf("w3_lat_%0dx%0d", i, j), lat, 3);
            end
        end

        // Signed corners.
        run8(8'h80, 8'h80, 1, p8, lat, bcnt); chk("s_80x80", p8, 16'h4000);
        run8(8'hFF, 8'h01, 1, p8, lat, bcnt); chk("s_FFx01", p8, 16'hFFFF);
        run8(8'h7F, 8'h80, 1, p8, lat, bcnt); chk("s_7Fx80", p8, 16'hC080);
        run8(8'h00, 8'h80, 1, p8, lat, bcnt); chk("s_00x80", p8, 16'h0000);
        chk("s_zero_lat", lat, 8);

        // Random operands in both modes.
        for (int k = 0; k < 40; k++) begin
            logic [7:0] ra, rb;
            bit rs;
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom_range(0, 1));
            run8(ra, rb, rs, p8, lat, bcnt);
            chk($sformatf("rnd_%0h_%0h_m%0d", ra, rb, rs), p8, ref_mul(ra, rb, rs, 8));
            chk("rnd_lat", lat, 8);
        end

        // Ignored start mid-CALC: one done, product 3*5.
        if8.a = 8'd3; if8.b = 8'd5; if8.signed_mode = 1'b0; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        repeat (3) tick();
        if8.a = 8'd9; if8.b = 8'd9; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        dcnt = 0; p8 = '0;
        for (int c = 0; c < 20; c++) begin
            if (if8.done) begin dcnt++; p8 = if8.product; end
            tick();
        end
        chk("ign_done_cnt", dcnt, 1);
        chk("ign_prod", p8, 15);

        // Hold: product stays 15 through idle and the next CALC.
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (if8.product !== 16'd15) bad++;
            tick();
        end
        chk("hold_idle", bad, 0);
        if8.a = 8'd0; if8.b = 8'd7; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        repeat (4) tick();
        chk("hold_calc", if8.product, 15);
        lat = 0;
        while (!if8.done && lat < 20) begin tick(); lat++; end
        chk("hold_new", if8.product, 0);
        tick();

        // start held high: captures every WIDTH+2 cycles.
        if8.a = 8'd2; if8.b = 8'd2; if8.start = 1'b1;
        lat = 0;
        while (!if8.done && lat < 30) begin tick(); lat++; end
        tick();
        t0 = 1;
        while (!if8.done && t0 < 30) begin tick(); t0++; end
        if8.start = 1'b0;
        chk("held_period", t0, 10);
        chk("held_prod", if8.product, 4);
        repeat (2) tick();

        // Unsigned max with busy/done widths.
        run8(8'hFF, 8'hFF, 0, p8, lat, bcnt);
        chk("u_FFxFF", p8, 16'hFE01);
        chk("u_busy_cycles", bcnt, 8);
        chk("u_done_width", if8.done, 0);

        // Reset in the middle of a multiplication.
        if8.a = 8'd12; if8.b = 8'd12; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        repeat (4) tick();
        chk("mid_busy_pre", if8.busy, 1);
        #2 rst8_n = 1'b0;
        #1;
        chk("mid_rst_busy", if8.busy, 0);
        chk("mid_rst_done", if8.done, 0);
        chk("mid_rst_prod", if8.product, 0);
        tick();
        rst8_n = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (if8.done) dcnt++;
            tick();
        end
        chk("mid_no_done", dcnt, 0);
        run8(8'd2, 8'd3, 0, p8, lat, bcnt);
        chk("mid_after", p8, 6);
        chk("mid_after_lat", lat, 8);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
